// File: rtl/axi_mem_slave_pkg.sv
// Shared constants and FSM state types for the AXI memory responder.
package axi_mem_slave_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Burst attributes implied by the port list; AxBURST/AxSIZE are not ported.
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] SIZE_8B     = 3'b011;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

endpackage

// File: rtl/axi_mem_slave_if.sv
// AXI4 write/read channel bundle between the cache master and the memory responder.
interface axi_mem_slave_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4
);
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [ID_W-1:0]     awid;
  logic [7:0]          awlen;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic [ID_W-1:0]     bid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [ID_W-1:0]     arid;
  logic [7:0]          arlen;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic [ID_W-1:0]     rid;
  logic                rlast;
  logic                rready;

  modport slave (
    input  awaddr, awvalid, awid, awlen, wdata, wstrb, wlast, wvalid, bready,
           araddr, arvalid, arid, arlen, rready,
    output awready, wready, bresp, bvalid, bid, arready, rdata, rresp, rvalid, rid, rlast
  );

  modport master (
    output awaddr, awvalid, awid, awlen, wdata, wstrb, wlast, wvalid, bready,
           araddr, arvalid, arid, arlen, rready,
    input  awready, wready, bresp, bvalid, bid, arready, rdata, rresp, rvalid, rid, rlast
  );
endinterface

// File: rtl/axi_mem_slave_bram.sv
// One-write/one-read word array with byte enables; registered read returns pre-write data.
module axi_mem_slave_bram #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                re,
  input  logic [ADDR_W-1:0]   raddr,
  output logic [DATA_W-1:0]   rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] bit_mask;

  // Expand byte strobes into a bit mask.
  always_comb begin
    bit_mask = '0;
    for (int b = 0; b < DATA_W/8; b++) begin
      bit_mask[b*8 +: 8] = {8{wstrb[b]}};
    end
  end

  // Byte-masked write: untouched bytes keep their old contents.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= (mem[waddr] & ~bit_mask) | (wdata & bit_mask);
    end
  end

  // Read port holds its output when not enabled so stalled beats stay stable.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end
endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 INCR-burst memory responder: one outstanding write and one outstanding read.
//
// state  | meaning
// W_IDLE | AWREADY high, waiting for a write address
// W_DATA | WREADY high, storing beats until the beat count reaches AWLEN
// W_RESP | BVALID high until BREADY
// R_IDLE | ARREADY high, waiting for a read address
// R_DATA | RVALID high, one beat per RREADY handshake, RLAST on beat ARLEN
module axi_mem_slave
  import axi_mem_slave_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int MEM_DEPTH      = 1024
) (
  input logic            clk,
  input logic            rst,
  axi_mem_slave_if.slave s_axi
);
  localparam int ADDR_LSB = $clog2(AXI_DATA_WIDTH/8);
  // Word index keeps every upper address bit so out-of-range beats are detected, never wrapped.
  localparam int IDX_W    = AXI_ADDR_WIDTH - ADDR_LSB;
  localparam int MEM_AW   = $clog2(MEM_DEPTH);
  localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(MEM_DEPTH);

  wr_state_t                   w_state;
  logic [IDX_W-1:0]            w_idx;
  logic [7:0]                  w_len, w_cnt;
  logic                        w_err;
  logic                        awready_q, wready_q, bvalid_q;
  logic [1:0]                  bresp_q;
  logic [AXI_ID_WIDTH-1:0]     bid_q;

  rd_state_t                   r_state;
  logic [IDX_W-1:0]            r_idx;
  logic [7:0]                  r_len, r_cnt;
  logic                        arready_q, rvalid_q, rlast_q;
  logic [1:0]                  rresp_q;
  logic [AXI_ID_WIDTH-1:0]     rid_q;

  logic                        w_hs, w_in_range, w_last_beat, w_beat_err;
  logic                        ar_hs, r_hs, mem_re;
  logic [IDX_W-1:0]            ar_idx, r_next_idx;
  logic [MEM_AW-1:0]           mem_raddr;
  logic [AXI_DATA_WIDTH-1:0]   mem_q;
  logic                        unused_ok;

  assign w_hs        = s_axi.wvalid && wready_q;
  assign w_in_range  = w_idx < DEPTH_IDX;
  assign w_last_beat = w_cnt == w_len;
  assign w_beat_err  = !w_in_range || (s_axi.wlast != w_last_beat);

  assign ar_hs      = s_axi.arvalid && arready_q;
  assign r_hs       = rvalid_q && s_axi.rready;
  assign ar_idx     = s_axi.araddr[AXI_ADDR_WIDTH-1:ADDR_LSB];
  assign r_next_idx = r_idx + 1'b1;
  assign mem_re     = ar_hs || (r_hs && !rlast_q);
  assign mem_raddr  = ar_hs ? ar_idx[MEM_AW-1:0] : r_next_idx[MEM_AW-1:0];

  // Byte offsets below a beat and the implied burst attributes carry no information here.
  assign unused_ok = ^{s_axi.awaddr[ADDR_LSB-1:0], s_axi.araddr[ADDR_LSB-1:0], BURST_INCR, SIZE_8B};

  axi_mem_slave_bram #(
    .DATA_W (AXI_DATA_WIDTH),
    .DEPTH  (MEM_DEPTH),
    .ADDR_W (MEM_AW)
  ) u_bram (
    .clk   (clk),
    .we    (w_hs && w_in_range),
    .waddr (w_idx[MEM_AW-1:0]),
    .wdata (s_axi.wdata),
    .wstrb (s_axi.wstrb),
    .re    (mem_re),
    .raddr (mem_raddr),
    .rdata (mem_q)
  );

  // Write channel FSM: address capture, beat storage with error accumulation, response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state   <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      bid_q     <= '0;
      w_idx     <= '0;
      w_len     <= '0;
      w_cnt     <= '0;
      w_err     <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (s_axi.awvalid && awready_q) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            bid_q     <= s_axi.awid;
            w_idx     <= s_axi.awaddr[AXI_ADDR_WIDTH-1:ADDR_LSB];
            w_len     <= s_axi.awlen;
            w_cnt     <= '0;
            w_err     <= 1'b0;
            w_state   <= W_DATA;
          end else begin
            awready_q <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            w_idx <= w_idx + 1'b1;
            w_cnt <= w_cnt + 8'd1;
            if (w_last_beat) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bresp_q  <= (w_err || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
              w_state  <= W_RESP;
            end else begin
              w_err <= w_err || w_beat_err;
            end
          end
        end
        W_RESP: begin
          if (bvalid_q && s_axi.bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            w_state   <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read channel FSM: each beat's response is decided when its array read is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rid_q     <= '0;
      r_idx     <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rid_q     <= s_axi.arid;
            r_idx     <= ar_idx;
            r_len     <= s_axi.arlen;
            r_cnt     <= '0;
            rlast_q   <= s_axi.arlen == 8'd0;
            rresp_q   <= (ar_idx < DEPTH_IDX) ? RESP_OKAY : RESP_SLVERR;
            r_state   <= R_DATA;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_DATA: begin
          if (r_hs) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              rresp_q   <= RESP_OKAY;
              arready_q <= 1'b1;
              r_state   <= R_IDLE;
            end else begin
              r_idx   <= r_next_idx;
              r_cnt   <= r_cnt + 8'd1;
              rlast_q <= (r_cnt + 8'd1) == r_len;
              rresp_q <= (r_next_idx < DEPTH_IDX) ? RESP_OKAY : RESP_SLVERR;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.bid     = bid_q;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rlast   = rlast_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.rid     = rid_q;
  // Error beats and idle cycles present zero data.
  assign s_axi.rdata   = (rvalid_q && rresp_q == RESP_OKAY) ? mem_q : '0;
endmodule

// File: tb/tb_axi_mem_slave.sv
module tb_axi_mem_slave;
  localparam int DEPTH = 1024;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_exp_t;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } r_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_mem_slave_if #(.ADDR_W(32), .DATA_W(64), .ID_W(4)) bus ();

  axi_mem_slave #(
    .AXI_ADDR_WIDTH (32),
    .AXI_DATA_WIDTH (64),
    .AXI_ID_WIDTH   (4),
    .MEM_DEPTH      (DEPTH)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .s_axi (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0] model [DEPTH];
  logic [63:0] wbuf  [256];
  logic [7:0]  sbuf  [256];
  b_exp_t      b_q [$];
  r_exp_t      r_q [$];
  int          rmode = 0;   // 0 always ready, 1 random, 2 pattern 1,0,0,1
  int          pat_i = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Ready drivers for B and R, changed just after the rising edge.
  initial begin
    bus.bready = 1'b0;
    bus.rready = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.bready = ($urandom_range(0, 3) != 0);
      case (rmode)
        0: bus.rready = 1'b1;
        1: bus.rready = ($urandom_range(0, 2) != 0);
        default: begin
          bus.rready = (pat_i % 4 == 0) || (pat_i % 4 == 3);
          pat_i++;
        end
      endcase
    end
  end

  // Monitor: pops the scoreboard on every B/R handshake and checks stalled beats hold.
  initial begin
    b_exp_t eb;
    r_exp_t er;
    logic stall_prev;
    logic [63:0] p_data;
    logic [7:0]  p_ctrl;
    stall_prev = 1'b0;
    p_data = '0;
    p_ctrl = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          check("r_stall_data", bus.rdata, p_data);
          check("r_stall_ctrl", {bus.rvalid, bus.rlast, bus.rresp, bus.rid}, p_ctrl);
        end
        if (bus.bvalid && bus.bready) begin
          if (b_q.size() == 0) begin
            n_checks++;
            $display("FAIL b_unexpected: got bid %h bresp %h expected no response", bus.bid, bus.bresp);
          end else begin
            eb = b_q.pop_front();
            check("bid", bus.bid, eb.id);
            check("bresp", bus.bresp, eb.resp);
          end
        end
        if (bus.rvalid && bus.rready) begin
          if (r_q.size() == 0) begin
            n_checks++;
            $display("FAIL r_unexpected: got rdata %h expected no beat", bus.rdata);
          end else begin
            er = r_q.pop_front();
            check("rdata", bus.rdata, er.data);
            check("rresp", bus.rresp, er.resp);
            check("rlast", bus.rlast, er.last);
            check("rid", bus.rid, er.id);
          end
        end
        stall_prev = bus.rvalid && !bus.rready;
        p_data = bus.rdata;
        p_ctrl = {bus.rvalid, bus.rlast, bus.rresp, bus.rid};
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ch: 0 AW, 1 W, 2 AR. Returns just after the handshaking edge.
  task automatic wait_hs(input int ch, input string name, output bit ok);
    logic rdy;
    ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      rdy = (ch == 0) ? bus.awready : (ch == 1) ? bus.wready : bus.arready;
      if (rdy) begin
        @(posedge clk); #1;
        ok = 1'b1;
        return;
      end
    end
    n_checks++;
    $display("FAIL %s: got no ready expected handshake within 300 cycles", name);
  endtask

  task automatic drain(input bit is_r, input string name);
    for (int t = 0; t < 2000; t++) begin
      if ((is_r ? r_q.size() : b_q.size()) == 0) return;
      @(posedge clk); #1;
    end
    n_checks++;
    $display("FAIL %s: got %0d pending responses expected 0", name, is_r ? r_q.size() : b_q.size());
    if (is_r) r_q.delete(); else b_q.delete();
  endtask

  task automatic model_write(input logic [28:0] idx, input logic [63:0] d, input logic [7:0] s);
    for (int b = 0; b < 8; b++)
      if (s[b]) model[idx[9:0]][b*8 +: 8] = d[b*8 +: 8];
  endtask

  task automatic send_aw(input logic [31:0] addr, input int len, input logic [3:0] id, output bit ok);
    bus.awaddr = addr; bus.awlen = 8'(len); bus.awid = id; bus.awvalid = 1'b1;
    wait_hs(0, "aw_handshake", ok);
    bus.awvalid = 1'b0;
  endtask

  // One W beat; model updated only when it was accepted.
  task automatic send_w(input logic [31:0] addr, input int i, input bit last, output bit ok);
    logic [28:0] idx;
    bus.wdata = wbuf[i]; bus.wstrb = sbuf[i]; bus.wlast = last; bus.wvalid = 1'b1;
    wait_hs(1, "w_handshake", ok);
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    idx = addr[31:3] + 29'(i);
    if (ok && idx < DEPTH) model_write(idx, wbuf[i], sbuf[i]);
  endtask

  // bad_beat: index of a beat whose WLAST is inverted (-1 for none).
  task automatic axi_write(input logic [31:0] addr, input int len, input logic [3:0] id, input int bad_beat);
    bit ok, err;
    logic [28:0] idx;
    send_aw(addr, len, id, ok);
    if (!ok) return;
    err = 1'b0;
    for (int i = 0; i <= len; i++) begin
      send_w(addr, i, (i == len) ^ (i == bad_beat), ok);
      if (!ok) return;
      idx = addr[31:3] + 29'(i);
      if (idx >= DEPTH || i == bad_beat) err = 1'b1;
    end
    b_q.push_back('{id: id, resp: err ? 2'b10 : 2'b00});
    @(negedge clk);
    check("bvalid_after_last", bus.bvalid, 1'b1);
    @(posedge clk); #1;
    drain(1'b0, "b_drain");
  endtask

  task automatic axi_read(input logic [31:0] addr, input int len, input logic [3:0] id);
    bit ok;
    logic [28:0] idx;
    r_exp_t e;
    bus.araddr = addr; bus.arlen = 8'(len); bus.arid = id; bus.arvalid = 1'b1;
    wait_hs(2, "ar_handshake", ok);
    bus.arvalid = 1'b0;
    if (!ok) return;
    for (int i = 0; i <= len; i++) begin
      idx = addr[31:3] + 29'(i);
      e.data = (idx < DEPTH) ? model[idx[9:0]] : 64'h0;
      e.resp = (idx < DEPTH) ? 2'b00 : 2'b10;
      e.last = (i == len);
      e.id   = id;
      r_q.push_back(e);
    end
    @(negedge clk);
    check("rvalid_latency", bus.rvalid, 1'b1);
    @(posedge clk); #1;
    drain(1'b1, "r_drain");
  endtask

  initial begin
    bit ok;
    int len;
    logic [31:0] addr;
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.awid = '0; bus.awlen = '0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.araddr = '0; bus.arvalid = 1'b0; bus.arid = '0; bus.arlen = '0;

    #12;
    check("reset_ctrl", {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, bus.rlast}, 6'b0);
    check("reset_resp_id", {bus.bresp, bus.rresp, bus.bid, bus.rid}, 12'b0);
    check("reset_rdata", bus.rdata, 64'h0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Fill the whole array with 256-beat bursts so every later read has a known value.
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 256; i++) begin
        wbuf[i] = {$urandom, $urandom};
        sbuf[i] = 8'hFF;
      end
      axi_write(32'(k * 2048), 255, 4'(k), -1);
    end

    // Single beat write and read-back.
    wbuf[0] = 64'hDEADBEEF_CAFEF00D; sbuf[0] = 8'hFF;
    axi_write(32'h0, 0, 4'h1, -1);
    axi_read(32'h0, 0, 4'h2);

    // Four-beat burst.
    for (int i = 0; i < 4; i++) begin wbuf[i] = 64'(i + 1); sbuf[i] = 8'hFF; end
    axi_write(32'h40, 3, 4'h3, -1);
    axi_read(32'h40, 3, 4'h5);

    // Partial write over word 0.
    wbuf[0] = '1; sbuf[0] = 8'h0F;
    axi_write(32'h0, 0, 4'h4, -1);
    axi_read(32'h0, 0, 4'h6);

    // Stalled read with RREADY pattern 1,0,0,1.
    rmode = 2; pat_i = 0;
    axi_read(32'h40, 3, 4'h7);
    rmode = 0;

    // Burst running off the end of the array.
    axi_read(32'(DEPTH * 8 - 8), 1, 4'h9);
    wbuf[0] = 64'h1111_2222_3333_4444; wbuf[1] = 64'h5555_6666_7777_8888;
    sbuf[0] = 8'hFF; sbuf[1] = 8'hFF;
    axi_write(32'(DEPTH * 8 - 8), 1, 4'hA, -1);
    axi_read(32'h0, 0, 4'hB);
    axi_read(32'(DEPTH * 8 - 8), 0, 4'hC);

    // Missing WLAST on the final beat.
    for (int i = 0; i < 3; i++) begin wbuf[i] = {$urandom, $urandom}; sbuf[i] = 8'hFF; end
    axi_write(32'h200, 2, 4'hD, 2);
    axi_read(32'h200, 2, 4'hE);

    // Reset while beat 2 of 4 is pending.
    for (int i = 0; i < 4; i++) begin wbuf[i] = {$urandom, $urandom}; sbuf[i] = 8'hFF; end
    send_aw(32'h100, 3, 4'h7, ok);
    send_w(32'h100, 0, 1'b0, ok);
    send_w(32'h100, 1, 1'b0, ok);
    bus.wdata = wbuf[2]; bus.wstrb = 8'hFF; bus.wvalid = 1'b1;
    @(negedge clk); rst = 1'b1; #1;
    check("rst_mid_ctrl", {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid}, 5'b0);
    @(posedge clk); #1; bus.wvalid = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check("rst_no_bvalid", bus.bvalid, 1'b0);
    check("rst_awready", bus.awready, 1'b1);
    @(negedge clk);
    check("rst_no_bvalid2", bus.bvalid, 1'b0);
    @(posedge clk); #1;
    axi_read(32'h100, 3, 4'h3);
    for (int i = 0; i < 4; i++) begin wbuf[i] = {$urandom, $urandom}; sbuf[i] = 8'hFF; end
    axi_write(32'h100, 3, 4'h8, -1);
    axi_read(32'h100, 3, 4'h8);

    // Randomized traffic, including bursts crossing the top of the array.
    rmode = 1;
    for (int n = 0; n < 30; n++) begin
      len  = $urandom_range(0, 7);
      addr = 32'($urandom_range(0, DEPTH + 4)) << 3;
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i <= len; i++) begin
          wbuf[i] = {$urandom, $urandom};
          sbuf[i] = 8'($urandom);
        end
        axi_write(addr, len, 4'($urandom), -1);
      end else begin
        axi_read(addr, len, 4'($urandom));
      end
    end
    rmode = 0;

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
